// File: rtl/ustc_sparse_encoder.sv
// ustc_sparse_encoder: scans dense rows and packs nonzeros into fixed-size {row,col,data}+ctrl blocks
module ustc_sparse_encoder #(
    parameter int M       = 16,
    parameter int K       = 16,
    parameter int N_UNIT  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_A    = DW_DATA + DW_ROW + DW_COL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [K*DW_DATA-1:0]       in_row,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_UNIT*DW_A-1:0]     out_block,
    output logic [N_UNIT*DW_CTRL-1:0]  out_ctrl,
    output logic                       out_last,
    output logic [3:0]                 num_blocks,
    output logic                       done,
    output logic                       overflow
);
    localparam int SW = $clog2(N_UNIT);
    typedef enum logic [2:0] {IDLE, ACCEPT, SCAN, EMIT, DONE} state_t;
    state_t                          state_q, state_d;
    logic [K-1:0][DW_DATA-1:0]       data_q, data_d;
    logic [N_UNIT-1:0][DW_A-1:0]     blk_q, blk_d;
    logic [N_UNIT-1:0][DW_CTRL-1:0]  ctrl_q, ctrl_d;
    logic [DW_ROW-1:0]               row_q, row_d;
    logic [DW_COL-1:0]               col_q, col_d, rcol_q, rcol_d;
    logic [SW-1:0]                   fill_q, fill_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic                            ovf_q, ovf_d, last_q, last_d, seen_q, seen_d;
    logic                            fin_q, fin_d, rend_q, rend_d;
    logic [DW_DATA-1:0]              elem;
    logic                            nz, full, rest_nz;

    assign in_ready   = state_q == ACCEPT;
    assign out_valid  = state_q == EMIT;
    assign out_last   = state_q == EMIT && fin_q;
    assign done       = state_q == DONE;
    assign out_block  = blk_q;
    assign out_ctrl   = ctrl_q;
    assign num_blocks = cnt_q;
    assign overflow   = ovf_q;

    // state and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            blk_q   <= '0;
            ctrl_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rcol_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
            seen_q  <= 1'b0;
            fin_q   <= 1'b0;
            rend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            blk_q   <= blk_d;
            ctrl_q  <= ctrl_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rcol_q  <= rcol_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            seen_q  <= seen_d;
            fin_q   <= fin_d;
            rend_q  <= rend_d;
        end
    end

    // next state: one column per SCAN cycle, a full or final block parks in EMIT until taken
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        blk_d   = blk_q;
        ctrl_d  = ctrl_q;
        row_d   = row_q;
        col_d   = col_q;
        rcol_d  = rcol_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        seen_d  = seen_q;
        fin_d   = fin_q;
        rend_d  = rend_q;
        elem    = data_q[col_q];
        nz      = elem != '0;
        full    = nz && fill_q == SW'(N_UNIT - 1);
        rest_nz = 1'b0;
        for (int c = 0; c < K; c++)
            if (c > int'(col_q) && data_q[c] != '0) rest_nz = 1'b1;
        case (state_q)
            IDLE: if (start) begin
                row_d   = '0;
                fill_d  = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                blk_d   = '0;
                ctrl_d  = '0;
                state_d = ACCEPT;
            end
            ACCEPT: if (in_valid) begin
                data_d  = in_row;
                last_d  = in_last || row_q == DW_ROW'(M - 1);
                seen_d  = 1'b0;
                col_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (nz) begin
                    blk_d[fill_q]  = {row_q, col_q, elem};
                    ctrl_d[fill_q] = DW_CTRL'({~seen_q, 1'b1});
                    seen_d         = 1'b1;
                    fill_d         = fill_q + 1'b1;
                end
                if (full) begin
                    rend_d  = col_q == DW_COL'(K - 1);
                    rcol_d  = col_q + 1'b1;
                    fin_d   = last_q && !rest_nz;
                    state_d = EMIT;
                end else if (col_q == DW_COL'(K - 1)) begin
                    row_d   = row_q + 1'b1;
                    fin_d   = 1'b1;
                    state_d = !last_q ? ACCEPT : fill_d != '0 ? EMIT : DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            EMIT: if (out_ready) begin
                cnt_d  = cnt_q == 4'hf ? cnt_q : cnt_q + 4'd1;
                ovf_d  = ovf_q || cnt_q == 4'hf;
                fill_d = '0;
                blk_d  = '0;
                ctrl_d = '0;
                if (fin_q) begin
                    state_d = DONE;
                end else if (rend_q) begin
                    row_d   = row_q + 1'b1;
                    state_d = last_q ? DONE : ACCEPT;
                end else begin
                    col_d   = rcol_q;
                    state_d = SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/ustc_sparse_encoder.md
Name: ustc_sparse_encoder

Overview:
Producer side of the compressed-A format consumed by the sparse core. Accepts a dense M x K matrix one row per handshake and scans each row for nonzero elements. Packs each nonzero into a {row, col, data} entry plus a ctrl nibble, and emits fixed-size blocks of N_UNIT entries over a valid/ready interface. On completion it reports the block count in the same 4-bit form as the core's num_blocks input.

Parameters:
M, 16, rows per matrix
K, 16, elements per row
N_UNIT, 32, entries per output block
DW_DATA, 8, element width
DW_ROW, 4, row-index width
DW_COL, 4, col-index width
DW_CTRL, 4, ctrl width per entry
DW_A, DW_DATA+DW_ROW+DW_COL, packed entry width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin new matrix; sampled only in IDLE
in_valid  in  1  row available
in_ready  out  1  encoder accepts row
in_row  in  K*DW_DATA  dense row; element c at [c*DW_DATA +: DW_DATA]
in_last  in  1  final row of matrix, qualified by in_valid
out_valid  out  1  block available
out_ready  in  1  consumer accepts block
out_block  out  N_UNIT*DW_A  slot s at [s*DW_A +: DW_A]: data [DW_DATA-1:0], col next DW_COL bits, row next DW_ROW bits
out_ctrl  out  N_UNIT*DW_CTRL  slot s at [s*DW_CTRL +: DW_CTRL]
out_last  out  1  current block is the final block
num_blocks  out  4  blocks emitted, saturating at 15
done  out  1  one-cycle completion pulse
overflow  out  1  sticky: more than 15 blocks produced

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - in_ready, out_valid, out_last, done, overflow, num_blocks are 0.
  - Block buffer and ctrl are all 0.
  - Row counter, column pointer and fill counter are 0.
- FSM states: IDLE, ACCEPT, SCAN, EMIT, DONE.
- IDLE: in_ready=0. When start=1: clear row counter, fill, block count and overflow, then go to ACCEPT. start is ignored in every other state.
- ACCEPT: in_ready=1; the only state with in_ready high. On in_valid && in_ready:
  - Capture in_row.
  - Latch is_last = in_last || (row counter == M-1).
  - Set col=0 and go to SCAN.
- SCAN: examine one element per cycle, at column col.
  - If the element is nonzero: write {row counter, col, data} to slot fill and set ctrl[0]=1. Set ctrl[1]=1 if this is the first nonzero of this row, else 0. ctrl[3:2]=0. Then fill++.
  - Block full: if the write fills slot N_UNIT-1, go to EMIT. Remember the resume point (col+1, or row end if col==K-1).
  - Row end (col==K-1, block not full): increment row counter, modulo 2^DW_ROW.
    - If is_last and fill>0: go to EMIT as the final block.
    - If is_last and fill==0: go to DONE.
    - Otherwise: go to ACCEPT.
  - Otherwise: col++.
- EMIT:
  - out_valid=1. out_block, out_ctrl and out_last stay stable until out_ready. out_last=1 only if no entries remain in the matrix.
  - On handshake:
    - Block count++, saturating at 15. Set overflow if the count was already 15.
    - fill=0. All slots and ctrl are cleared to 0.
    - Then: if final, go to DONE. Else if the resume point is the row end, apply the row-end rule. Else return to SCAN at the resume column.
  - out_valid falls the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE. num_blocks holds its value until the next accepted start.
- Unused slots in the final block: data, row, col and ctrl are all 0.
- A full block on the last nonzero of the last row is that row's final block: out_last=1, and no empty block follows.
- All-zero matrix: no block is emitted; done pulses; num_blocks=0.
- Latency:
  - First column is examined in the cycle after the row handshake.
  - A row costs K SCAN cycles plus stalls in EMIT.
  - A full block asserts out_valid the cycle after its last entry is written.

Test Plan:
- Diagonal 16x16, A[i][i]=i+1, rows fed back-to-back, in_last on row 15, out_ready=1 -> one block: slot i = {row=i, col=i, data=i+1}, ctrl=0x3 for i<16; slots 16-31 and their ctrl = 0; out_last=1; num_blocks=1; done pulses once.
- Dense all-0x01 16x16 -> 8 full blocks. Block b slot s = row 2b+(s/16), col s%16. ctrl[1] set at slots 0 and 16. out_last only on block 8. num_blocks=8.
- All-zero matrix -> out_valid never asserts; done pulses after 16*K+row-handshake cycles; num_blocks=0.
- Diagonal case with out_ready held 0 for 5 cycles during EMIT -> out_block/out_ctrl/out_last stable; in_ready=0 throughout; output identical to the first test.
- N_UNIT=8, dense all-0x01 -> 32 blocks emitted; overflow rises on block 16 and stays 1; num_blocks=15; out_last on block 32 only.
- Assert reset during EMIT of the dense case -> out_valid, in_ready and overflow are 0 in the same cycle; a following start plus the diagonal matrix reproduces the first test exactly.
